// File: rtl/gf233_inverse.sv
// GF(2^233) inverter (f = x^233 + x^74 + 1) using Itoh-Tsujii exponentiation.
// A recursive Karatsuba multiplier provides the one field multiply per MUL step.

module karatsuba_recurse #(
    parameter int WIDTH     = 233,
    parameter int THRESHOLD = 29
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-2:0] p_o
);
    localparam int P = 2 * WIDTH - 1;

    if (WIDTH <= THRESHOLD) begin : g_school
        always_comb begin
            p_o = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (b_i[i]) p_o = p_o ^ (P'(a_i) << i);
            end
        end
    end else begin : g_split
        localparam int LW = WIDTH / 2;
        localparam int HW = WIDTH - LW;
        localparam int PM = 2 * HW - 1;

        logic [LW-1:0]     a_lo, b_lo;
        logic [HW-1:0]     a_hi, b_hi, a_mid, b_mid;
        logic [2*LW-2:0]   p_lo;
        logic [2*HW-2:0]   p_hi, p_mid, p_cross;

        assign a_lo  = a_i[LW-1:0];
        assign b_lo  = b_i[LW-1:0];
        assign a_hi  = a_i[WIDTH-1:LW];
        assign b_hi  = b_i[WIDTH-1:LW];
        assign a_mid = a_hi ^ HW'(a_lo);
        assign b_mid = b_hi ^ HW'(b_lo);

        karatsuba_recurse #(.WIDTH(LW), .THRESHOLD(THRESHOLD)) u_lo (
            .a_i (a_lo),
            .b_i (b_lo),
            .p_o (p_lo)
        );

        karatsuba_recurse #(.WIDTH(HW), .THRESHOLD(THRESHOLD)) u_hi (
            .a_i (a_hi),
            .b_i (b_hi),
            .p_o (p_hi)
        );

        karatsuba_recurse #(.WIDTH(HW), .THRESHOLD(THRESHOLD)) u_mid (
            .a_i (a_mid),
            .b_i (b_mid),
            .p_o (p_mid)
        );

        // Middle term: (ah+al)(bh+bl) - ah*bh - al*bl, subtraction is XOR in GF(2)
        assign p_cross = p_mid ^ p_hi ^ PM'(p_lo);
        assign p_o     = P'(p_lo) ^ (P'(p_cross) << LW) ^ (P'(p_hi) << (2 * LW));
    end

endmodule

module gf233_inverse #(
    parameter int THRESHOLD = 29
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [232:0] a_in,
    output logic         busy,
    output logic         done,
    output logic [232:0] inv_out
);
    typedef enum logic [2:0] {StIdle, StSqr, StMul, StFin, StDone} state_e;

    state_e       state_q;
    logic [232:0] acc_q, a_reg_q, base_q;
    logic [3:0]   step_q;
    logic [6:0]   sq_cnt_q;
    logic         busy_q, done_q;

    logic [232:0] op;
    logic [464:0] prod;
    logic [232:0] mul_res, sq_res;

    // x^233 == x^74 + 1; fold from the top down so cascaded terms are caught
    function automatic logic [232:0] reduce(input logic [464:0] c);
        logic [464:0] r;
        r = c;
        for (int i = 464; i >= 233; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i - 233] = r[i - 233] ^ 1'b1;
                r[i - 159] = r[i - 159] ^ 1'b1;
            end
        end
        return r[232:0];
    endfunction

    function automatic logic [464:0] sq_expand(input logic [232:0] v);
        logic [464:0] s;
        s = '0;
        for (int i = 0; i < 233; i++) s[2 * i] = v[i];
        return s;
    endfunction

    function automatic logic [6:0] sq_len(input logic [3:0] s);
        logic [6:0] j;
        unique case (s)
            4'd2:    j = 7'd3;
            4'd4:    j = 7'd7;
            4'd5:    j = 7'd14;
            4'd7:    j = 7'd29;
            4'd8:    j = 7'd58;
            4'd9:    j = 7'd116;
            default: j = 7'd1;
        endcase
        return j;
    endfunction

    // Steps 0,1,3,6 extend the chain by one (multiply by a); the rest double it
    always_comb begin
        op = base_q;
        if (step_q == 4'd0 || step_q == 4'd1 || step_q == 4'd3 || step_q == 4'd6) begin
            op = a_reg_q;
        end
    end

    karatsuba_recurse #(.WIDTH(233), .THRESHOLD(THRESHOLD)) u_mul (
        .a_i (acc_q),
        .b_i (op),
        .p_o (prod)
    );

    assign mul_res = reduce(prod);
    assign sq_res  = reduce(sq_expand(acc_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            a_reg_q  <= '0;
            base_q   <= '0;
            step_q   <= '0;
            sq_cnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        acc_q    <= a_in;
                        a_reg_q  <= a_in;
                        base_q   <= a_in;
                        step_q   <= 4'd0;
                        sq_cnt_q <= sq_len(4'd0);
                        state_q  <= StSqr;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StSqr: begin
                    acc_q    <= sq_res;
                    sq_cnt_q <= sq_cnt_q - 7'd1;
                    if (sq_cnt_q == 7'd1) state_q <= StMul;
                end
                StMul: begin
                    acc_q <= mul_res;
                    if (step_q < 4'd9) begin
                        step_q   <= step_q + 4'd1;
                        base_q   <= mul_res;
                        sq_cnt_q <= sq_len(step_q + 4'd1);
                        state_q  <= StSqr;
                    end else begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    acc_q   <= sq_res;
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign inv_out = acc_q;

endmodule

// File: tb/tb_gf233_inverse.sv
// Directed-vector bench for gf233_inverse: known inverses, latency, busy/done timing,
// start masking, back-to-back start, mid-operation reset and golden-model random checks.

module tb_gf233_inverse;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [232:0] a_in;
    logic         busy;
    logic         done;
    logic [232:0] inv_out;

    int n_vec = 0;
    int n_bad = 0;

    gf233_inverse #(.THRESHOLD(29)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .busy    (busy),
        .done    (done),
        .inv_out (inv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [232:0] a;
        logic [232:0] inv;
    } vec_t;

    function automatic logic [232:0] mono(input int k);
        logic [232:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [232:0] rnd();
        logic [232:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[200:0], 32'($urandom)};
        return r;
    endfunction

    // Shift-and-add field multiply, reducing one bit per shift
    function automatic logic [232:0] gf_mul(input logic [232:0] x, input logic [232:0] y);
        logic [232:0] acc, sh;
        logic         c;
        acc = '0;
        sh  = x;
        for (int i = 0; i < 233; i++) begin
            if (y[i]) acc = acc ^ sh;
            c  = sh[232];
            sh = {sh[231:0], 1'b0};
            if (c) sh = sh ^ mono(74) ^ mono(0);
        end
        return acc;
    endfunction

    task automatic check_vec(input string name, input logic [232:0] got, input logic [232:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic launch(input logic [232:0] a);
        a_in  = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = rnd();
    endtask

    // Cycle c is the interval after the c-th edge following the accepting edge
    task automatic wait_done(input bit glitch, output logic [232:0] res, output int lat,
                             output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        res      = '0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (glitch) begin
                start = (c == 5 || c == 100);
                if (start) a_in = rnd();
            end
            if (done) begin
                lat = c;
                res = inv_out;
                if (busy) busy_bad++;
                break;
            end else if (!busy) begin
                busy_bad++;
            end
        end
        if (glitch) start = 1'b0;
    endtask

    vec_t         tbl[7];
    logic [232:0] res, res2, ra;
    int           lat, bb, hits;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        #3;
        check_vec("reset_inv_out", inv_out, '0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{a: mono(0),              inv: mono(0)};
        tbl[1] = '{a: mono(1),              inv: mono(232) ^ mono(73)};
        tbl[2] = '{a: '0,                   inv: '0};
        tbl[3] = '{a: mono(232) ^ mono(73), inv: mono(1)};
        tbl[4] = '{a: mono(2),              inv: mono(231) ^ mono(72)};
        tbl[5] = '{a: mono(74),             inv: mono(159) ^ mono(0)};
        tbl[6] = '{a: mono(5),              inv: mono(228) ^ mono(69)};

        for (int i = 0; i < 7; i++) begin
            launch(tbl[i].a);
            wait_done(1'b0, res, lat, bb);
            check_vec($sformatf("vec%0d_inv", i), res, tbl[i].inv);
            check_int($sformatf("vec%0d_latency", i), lat, 243);
            check_int($sformatf("vec%0d_busy", i), bb, 0);
            hits = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done || busy || inv_out !== tbl[i].inv) hits++;
            end
            check_int($sformatf("vec%0d_hold", i), hits, 0);
        end

        // Start pulses at cycles 5 and 100 must be ignored
        launch(mono(1));
        wait_done(1'b1, res, lat, bb);
        check_vec("glitch_inv", res, mono(232) ^ mono(73));
        check_int("glitch_latency", lat, 243);
        check_int("glitch_busy", bb, 0);
        @(negedge clk);

        // Start held high through done: second op begins in the DONE cycle
        a_in  = mono(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        a_in = rnd();
        wait_done(1'b0, res, lat, bb);
        check_vec("b2b_first_inv", res, mono(228) ^ mono(69));
        check_int("b2b_first_latency", lat, 243);
        a_in = mono(74);
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = rnd();
        wait_done(1'b0, res2, lat, bb);
        check_vec("b2b_second_inv", res2, mono(159) ^ mono(0));
        check_int("b2b_second_latency", lat, 243);
        check_int("b2b_second_busy", bb, 0);
        @(negedge clk);

        // Reset asserted at cycle 120 aborts the operation
        launch(mono(1));
        repeat (119) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("abort_inv_out", inv_out, '0);
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done || busy) hits++;
        end
        check_int("abort_no_done", hits, 0);
        launch(mono(2));
        wait_done(1'b0, res, lat, bb);
        check_vec("after_abort_inv", res, mono(231) ^ mono(72));
        check_int("after_abort_latency", lat, 243);

        // Random nonzero operands against the golden multiply
        for (int i = 0; i < 20; i++) begin
            ra = rnd();
            if (ra == '0) ra = mono(0);
            launch(ra);
            wait_done(1'b0, res, lat, bb);
            check_vec($sformatf("rand%0d_product", i), gf_mul(ra, res), mono(0));
            check_int($sformatf("rand%0d_latency", i), lat, 243);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
